uart_tx_mmio: RTL and testbench

//  CPU-side UART transmitter. It sends bytes that software writes over the IO bus (ioWrite path)
//  out on the board tx pin at a fixed baud rate. It is the outbound counterpart of the UART

---
 rtl/uart_tx_mmio.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: CPU-side UART transmitter, byte FIFO feeding an 8N1 shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frames).
module uart_tx_mmio #(
   parameter int CLK_HZ     = 23_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          fifo_full,
   output logic          fifo_empty,
   output logic [CW-1:0] fifo_count,
   output logic          tx_busy,
   output logic          tx
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int BW  = $clog2(DIV);

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_mmio: DIV must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_chk
      $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2, >= 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_e;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          push, pop;
   logic [7:0]    head;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          baud_end;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   // A write to a full FIFO is dropped even if a pop frees a slot this cycle
   assign push     = wr_en & ~full_q;
   assign head     = mem_q[rptr_q];
   assign baud_end = (baud_q == BW'(DIV - 1));

   // FIFO storage; contents outside the pointers are don't-care, so no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wr_data;
   end

   // FIFO pointer/count/flag next state, flags derived from the new count
   always_comb begin
      wptr_d = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
      full_d  = (cnt_d == CW'(FIFO_DEPTH));
      empty_d = (cnt_d == '0);
   end

   // FIFO bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Shifter state register; tx and busy registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state: each non-idle bit lasts DIV cycles; STOP chains frames
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!empty_q) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!empty_q) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef UART_TX_PARITY_EN
      par_d = pop ? ^head : par_q;
`endif
   end

   // Output decode from the next state so tx is a clean registered bit
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign fifo_full  = full_q;
   assign fifo_empty = empty_q;
   assign fifo_count = cnt_q;
   assign tx_busy    = busy_q;
   assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio at DIV=10, depth 16.
// Build with UART_TX_PARITY_EN to exercise 11-bit frames.
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       fifo_full;
   logic       fifo_empty;
   logic [4:0] fifo_count;
   logic       tx_busy;
   logic       tx;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   uart_tx_mmio #(
      .CLK_HZ    (1_000_000),
      .BAUD      (100_000),
      .FIFO_DEPTH(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .fifo_full (fifo_full),
      .fifo_empty(fifo_empty),
      .fifo_count(fifo_count),
      .tx_busy   (tx_busy),
      .tx        (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (i == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   // Checks {tx,tx_busy} every cycle of a frame from cycle 'skip';
   // 'inj' drives a write on the final stop-bit cycle.
   task automatic frame(input logic [7:0] b,
                        input int skip,
                        input bit inj);
      for (int t = skip; t < NB * 10; t++) begin
         chk($sformatf("frm %02h c%0d", b, t),
             32'({tx, tx_busy}),
             32'({exp_bit(b, t / 10), 1'b1}));
         if (inj && t == NB * 10 - 1) begin
            wr_en   = 1'b1;
            wr_data = 8'hEE;
         end
         @(negedge clk);
         wr_en = 1'b0;
      end
   endtask

   task automatic quiet(input string tag, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
         @(negedge clk);
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(tx_busy), 32'd0);
      chk("rst empty", 32'(fifo_empty), 32'd1);
      chk("rst full", 32'(fifo_full), 32'd0);
      chk("rst count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single byte, start bit from the edge after the write
      wr_en   = 1'b1;
      wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      chk("t1 count", 32'(fifo_count), 32'd1);
      chk("t1 idle", 32'({tx, tx_busy}), 32'b10);
      @(negedge clk);
      chk("t1 popped", 32'(fifo_count), 32'd0);
      chk("t1 empty", 32'(fifo_empty), 32'd1);
      frame(8'h55, 0, 1'b0);
      chk("t1 end", 32'({tx, tx_busy}), 32'b10);
      quiet("t1 quiet", 5);

      // back-to-back frames with no idle gap
      wr_en   = 1'b1;
      wr_data = 8'hA3;
      @(negedge clk);
      chk("t2 count a", 32'(fifo_count), 32'd1);
      wr_data = 8'h0F;
      @(negedge clk);
      wr_en = 1'b0;
      chk("t2 count b", 32'(fifo_count), 32'd1);
      frame(8'hA3, 0, 1'b0);
      chk("t2 count c", 32'(fifo_count), 32'd0);
      frame(8'h0F, 0, 1'b0);
      chk("t2 end", 32'({tx, tx_busy}), 32'b10);
      quiet("t2 quiet", 5);

      // 18 writes: 1 popped, 16 queued, last dropped
      for (int i = 0; i < 18; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(8'h30 + i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      chk("t3 count", 32'(fifo_count), 32'd16);
      chk("t3 full", 32'(fifo_full), 32'd1);
      chk("t3 empty", 32'(fifo_empty), 32'd0);
      // write while full on the STOP->START pop edge
      frame(8'h30, 16, 1'b1);
      chk("t4 count", 32'(fifo_count), 32'd15);
      chk("t4 full", 32'(fifo_full), 32'd0);
      for (int i = 1; i < 17; i++) begin
         frame(8'(8'h30 + i), 0, 1'b0);
      end
      chk("t3 end", 32'({tx, tx_busy}), 32'b10);
      chk("t3 empty end", 32'(fifo_empty), 32'd1);
      quiet("t3 quiet", 3 * NB * 10);

      // reset in the middle of a data bit with 3 bytes queued
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = (i == 0) ? 8'hFF : 8'(8'h11 * i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      repeat (40) @(negedge clk);
      chk("t5 pre count", 32'(fifo_count), 32'd3);
      chk("t5 pre line", 32'({tx, tx_busy}), 32'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5 line", 32'({tx, tx_busy}), 32'b10);
      chk("t5 count", 32'(fifo_count), 32'd0);
      chk("t5 flags", 32'({fifo_empty, fifo_full}), 32'b10);
      quiet("t5 quiet", 4 * NB * 10);

      // parity cases: 0x07 odd weight, 0x03 even weight
      wr_en   = 1'b1;
      wr_data = 8'h07;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      frame(8'h07, 0, 1'b0);
      chk("t6 end a", 32'({tx, tx_busy}), 32'b10);
      wr_en   = 1'b1;
      wr_data = 8'h03;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      frame(8'h03, 0, 1'b0);
      chk("t6 end b", 32'({tx, tx_busy}), 32'b10);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
